// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Frame states, data width and per-byte line configuration.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  typedef struct packed {
    logic parity_en;
    logic parity_odd;
    logic two_stop;
  } cfg_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-entry holding buffer feeding a
// start/data/parity/stop shifter advanced by baud_tick.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 txd,
  output logic                 busy
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  state_t               state, state_n;
  logic [DATA_BITS-1:0] buf_data;
  cfg_t                 buf_cfg;
  logic                 buf_full;
  logic [DATA_BITS-1:0] shifter, shifter_n;
  logic [IW-1:0]        idx, idx_n;
  logic                 par, par_n;
  logic                 f_par_en, f_par_en_n;
  logic                 f_two, f_two_n;
  logic                 txd_n;
  logic                 load;
  logic                 shift;
  logic                 frame_end;
  logic                 accept;

  assign tx_ready = !buf_full && !rst;
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    load      = 1'b0;
    shift     = 1'b0;
    frame_end = 1'b0;
    if (baud_tick) begin
      case (state)
        IDLE: begin
          if (buf_full) begin
            load    = 1'b1;
            state_n = START;
          end
        end
        START: begin
          state_n = DATA;
          idx_n   = '0;
        end
        DATA: begin
          shift = 1'b1;
          if (idx == LAST) begin
            idx_n   = '0;
            state_n = f_par_en ? PARITY : STOP1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
        PARITY: state_n = STOP1;
        STOP1: begin
          if (f_two) state_n = STOP2;
          else       frame_end = 1'b1;
        end
        STOP2:   frame_end = 1'b1;
        default: state_n = IDLE;
      endcase
    end
    // Refilled buffer chains straight into the next start bit.
    if (frame_end) begin
      if (buf_full) begin
        load    = 1'b1;
        state_n = START;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_comb begin
    shifter_n  = shifter;
    par_n      = par;
    f_par_en_n = f_par_en;
    f_two_n    = f_two;
    if (load) begin
      shifter_n  = buf_data;
      par_n      = (^buf_data) ^ buf_cfg.parity_odd;
      f_par_en_n = buf_cfg.parity_en;
      f_two_n    = buf_cfg.two_stop;
    end else if (shift) begin
      shifter_n = shifter >> 1;
    end
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shifter_n[0];
      PARITY:  txd_n = par_n;
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      buf_cfg  <= '0;
      shifter  <= '0;
      idx      <= '0;
      par      <= 1'b0;
      f_par_en <= 1'b0;
      f_two    <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      shifter  <= shifter_n;
      idx      <= idx_n;
      par      <= par_n;
      f_par_en <= f_par_en_n;
      f_two    <= f_two_n;
      txd      <= txd_n;
      busy     <= (state_n != IDLE);
      if (accept) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
        buf_cfg  <= '{parity_en, parity_odd, two_stop};
      end else if (load) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer; a monitor records the
// line value and busy for each bit period after every baud_tick.
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       parity_en;
  logic       parity_odd;
  logic       two_stop;
  logic       txd;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cnt      = 0;

  logic txq[$];
  logic bsq[$];

  uart_tx_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .two_stop  (two_stop),
    .txd       (txd),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (baud_tick) begin
        txq.push_back(txd);
        bsq.push_back(busy);
      end
      cnt       = (cnt == 3) ? 0 : cnt + 1;
      baud_tick = (cnt == 0);
    end
  end

  task automatic clear_q();
    txq.delete();
    bsq.delete();
  endtask

  task automatic wait_q(input int n);
    int k = 0;
    while (txq.size() < n && k < 4000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (txq.size() < n) begin
      failures++;
      $display("FAIL wait_q entries=%0d need=%0d", txq.size(), n);
    end
  endtask

  task automatic find_start(output int s);
    int k = 0;
    s = -1;
    while (s < 0 && k < 4000) begin
      for (int i = 0; i < bsq.size(); i++)
        if (s < 0 && bsq[i] === 1'b1) s = i;
      if (s < 0) begin
        @(negedge clk);
        k++;
      end
    end
    checks++;
    if (s < 0) begin
      failures++;
      $display("FAIL find_start no busy tick seen");
      s = 0;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe,
                      input logic po, input logic ts);
    int k = 0;
    tx_data    = d;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    tx_valid   = 1'b1;
    while (!tx_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (k >= 400) begin
      failures++;
      $display("FAIL send_timeout data=%0h", d);
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((busy || !tx_ready) && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input logic [31:0] exp,
                             input int len);
    int s;
    find_start(s);
    wait_q(s + len + 1);
    for (int i = 0; i <= len; i++) begin
      checks++;
      if (txq[s+i] !== exp[i]) begin
        failures++;
        $display("FAIL %s txd bit%0d got=%b exp=%b", nm, i, txq[s+i], exp[i]);
      end
      checks++;
      if (bsq[s+i] !== (i < len)) begin
        failures++;
        $display("FAIL %s busy bit%0d got=%b exp=%b", nm, i, bsq[s+i], i < len);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin
      failures++;
      $display("FAIL reset_txd got=%b exp=1", txd);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", tx_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_ready got=%b exp=1", tx_ready);
    end
  endtask

  task automatic test_basic();
    clear_q();
    send(8'h55, 1'b0, 1'b0, 1'b0);
    check_frame("f55", 32'h6AA, 10);
    drain();
  endtask

  task automatic test_parity();
    clear_q();
    send(8'hA3, 1'b1, 1'b0, 1'b0);
    check_frame("a3_even", 32'hD46, 11);
    drain();
    clear_q();
    send(8'hA3, 1'b1, 1'b1, 1'b0);
    parity_odd = 1'b0;
    parity_en  = 1'b0;
    check_frame("a3_odd", 32'hF46, 11);
    drain();
  endtask

  task automatic test_back_to_back();
    clear_q();
    send(8'h00, 1'b0, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b0, 1'b1);
    check_frame("b2b", 32'h7FF600, 22);
    drain();
  endtask

  task automatic test_buffer_full();
    int s;
    int k = 0;
    logic [7:0] got;
    logic [7:0] exp [3];
    exp[0] = 8'h11;
    exp[1] = 8'h22;
    exp[2] = 8'h33;
    clear_q();
    send(8'h11, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0, 1'b0);
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready got=%b exp=0", tx_ready);
    end
    repeat (8) @(negedge clk);
    tx_data = 8'h33;
    while (!tx_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    find_start(s);
    wait_q(s + 31);
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (txq[s+10*f] !== 1'b0) begin
        failures++;
        $display("FAIL full_start%0d got=%b exp=0", f, txq[s+10*f]);
      end
      for (int b = 0; b < 8; b++) got[b] = txq[s+10*f+1+b];
      checks++;
      if (got !== exp[f]) begin
        failures++;
        $display("FAIL full_byte%0d got=%0h exp=%0h", f, got, exp[f]);
      end
    end
    checks++;
    if (bsq[s+30] !== 1'b0) begin
      failures++;
      $display("FAIL full_end_busy got=%b exp=0", bsq[s+30]);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int s;
    int nb = 0;
    clear_q();
    send(8'hC5, 1'b0, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    find_start(s);
    wait_q(s + 5);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin
      failures++;
      $display("FAIL midrst_txd got=%b exp=1", txd);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_busy got=%b exp=0", busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready got=%b exp=1", tx_ready);
    end
    clear_q();
    repeat (60) @(negedge clk);
    for (int i = 0; i < bsq.size(); i++)
      if (bsq[i] !== 1'b0 || txq[i] !== 1'b1) nb++;
    checks++;
    if (nb != 0 || bsq.size() < 10) begin
      failures++;
      $display("FAIL midrst_lost active=%0d ticks=%0d exp=0", nb, bsq.size());
    end
  endtask

  task automatic test_tick_handshake();
    int k = 0;
    @(negedge clk);
    #1;
    while (!baud_tick && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    clear_q();
    tx_data  = 8'h5A;
    parity_en = 1'b0;
    two_stop = 1'b0;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL coinc_ready got=%b exp=0", tx_ready);
    end
    wait_q(2);
    checks++;
    if (txq[0] !== 1'b1 || bsq[0] !== 1'b0) begin
      failures++;
      $display("FAIL coinc_first txd=%b busy=%b exp=1,0", txq[0], bsq[0]);
    end
    checks++;
    if (txq[1] !== 1'b0 || bsq[1] !== 1'b1) begin
      failures++;
      $display("FAIL coinc_start txd=%b busy=%b exp=0,1", txq[1], bsq[1]);
    end
    drain();
  endtask

  initial begin
    rst        = 1'b1;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_buffer_full();
    test_reset_mid();
    test_tick_handshake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit serializer that sits directly downstream of the baud-rate enable generator. It accepts bytes over a valid/ready handshake into a one-entry holding buffer, then shifts each frame out on `txd` one bit per `baud_tick`: start bit, 8 data bits LSB-first, optional parity and 1 or 2 stop bits. Frames run back-to-back with no idle gap whenever the buffer is refilled in time.

## Interface
- `DATA_BITS`, 8, data bits per frame; fixed at 8 in this revision.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `baud_tick`  in  1  one-cycle bit-period strobe from the baud generator; never asserted on consecutive cycles.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  holding buffer empty; a byte is accepted on `tx_valid && tx_ready`.
- `parity_en`  in  1  append a parity bit.
- `parity_odd`  in  1  odd parity when 1, even when 0.
- `two_stop`  in  1  two stop bits when 1, one when 0.
- `txd`  out  1  serial line, idle high.
- `busy`  out  1  a frame is on the line (any state other than IDLE).

## Operation
- Holding buffer: 8-bit data plus a 3-bit config snapshot (`parity_en`, `parity_odd`, `two_stop`), latched at acceptance.
- `tx_ready = !buf_full && !rst`.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2. All transitions occur only on cycles with `baud_tick` = 1.
- IDLE: on a tick with `buf_full` (as registered before that cycle), load the shifter and config from the buffer, clear `buf_full`, and go to START.
- START → DATA with bit index 0.
- DATA: on each tick shift right and increment the index; after index 7, go to PARITY if `parity_en`, otherwise STOP1.
- PARITY → STOP1.
- STOP1 → STOP2 if `two_stop`; otherwise take the frame-end path.
- STOP2 → frame-end path.
- Frame end: if `buf_full`, load the buffer and go directly to START, with no idle bit. Otherwise go to IDLE.
- Parity bit = XOR of the 8 data bits, inverted when `parity_odd`.
- `txd` per state: START 0, DATA shifter[0], PARITY parity bit, STOP1/STOP2/IDLE 1.
- Changes to the config inputs never affect a byte already accepted.

## Timing
- `txd`, `busy` and the state register are registered. `txd` changes on the cycle after the `baud_tick` that caused the transition, so each bit lasts exactly one tick period.
- Frame length is 10, 11, 11 or 12 tick periods (parity off/on × stop 1/2).
- Acceptance: `tx_ready` drops the cycle after the handshake and rises the cycle after the buffer is loaded into the shifter.
- Tick and handshake in the same cycle with an empty buffer: the byte is stored. The tick does not start the byte; it starts on the next tick.
- While `tx_ready` = 0, `tx_data` and `tx_valid` are ignored and the buffer is not overwritten.
- Reset values: `txd` = 1, `busy` = 0, state IDLE, `buf_full` = 0, bit index 0. `tx_ready` = 0 while `rst` is high and 1 on the first cycle after.
- Reset mid-frame: the frame is aborted, `txd` returns to 1 on the next edge, and the buffered byte is discarded.
- `baud_tick` is ignored while `rst` is high.

## Structure
- Shared package `uart_pkg`:
  - state enum: IDLE, START, DATA, PARITY, STOP1, STOP2;
  - `UART_DATA_BITS` = 8;
  - config struct: `parity_en`, `parity_odd`, `two_stop`.
- Single module, no sub-modules. The baud-tick generator stays external and is instantiated by the parent.

## Test plan
The bench uses a `baud_tick` every 4 cycles.
- 0x55, no parity, 1 stop → `txd` per tick: 0,1,0,1,0,1,0,1,0,1; then idle 1; `busy` is high for exactly 10 tick periods.
- 0xA3, even parity, 1 stop → data bits 1,1,0,0,0,1,0,1, parity 0. Same byte with odd parity → parity bit 1; frame is 11 ticks.
- 0x00 then 0xFF, `two_stop` = 1, second byte accepted during the first frame → second start bit immediately follows the second stop bit; no idle tick between frames.
- Buffer full: third byte offered while one frame is shifting and one is buffered → `tx_ready` = 0, `tx_data` changes are ignored, and the third byte is accepted only once the buffer drains.
- `rst` pulsed during DATA bit 3 → `txd` = 1 the next cycle, `busy` = 0, the buffered byte is lost, and `tx_ready` = 1 after release.
- Handshake coincident with a `baud_tick` in IDLE → start bit appears after the following tick, not the coincident one.
